muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage, directly downstream of the register file. It consumes the RS/RT operand pair and executes MULT, MULTU, DIV and DIVU over 33 cycles. Results go to dedicated HI/LO registers, which it also owns for MTHI/MTLO. The hazard unit stalls on `busy_o`; MFHI/MFLO read `hi_o`/`lo_o`.

---
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO ownership (MTHI/MTLO).
// Latency: 33 cycles busy per operation; result on hi_o/lo_o with done_o one cycle after.
// Backpressure: none internal; upstream must stall while busy_o (start/writes ignored).
// Ports: clk_i/rst_i (async active-low); start_i+op_i launch an op on RSdata_i/RTdata_i;
//        hilo_we_i[1:0] writes HI/LO from RSdata_i when idle; busy_o/done_o/div0_o status;
//        hi_o/lo_o are the architectural HI/LO registers.
module muldiv_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] RSdata_i,
    input  logic [31:0] RTdata_i,
    input  logic [1:0]  hilo_we_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        div0_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;       // op_q[1]: divide, op_q[0]: unsigned
    logic [31:0] a_q, a_d;         // multiplicand / dividend magnitude (dividend shifts left)
    logic [31:0] b_q, b_d;         // multiplier (shifts right) / divisor magnitude
    logic [31:0] rs_q, rs_d;       // raw dividend for the divide-by-zero result
    logic [63:0] acc_q, acc_d;     // product; low half holds the quotient for divides
    logic [32:0] rem_q, rem_d;     // partial remainder
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;     // negate product / quotient
    logic        rneg_q, rneg_d;   // negate remainder
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d, div0_q, div0_d;

    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [33:0] div_sub;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        a_mag     = (!op_i[0] && RSdata_i[31]) ? (~RSdata_i + 32'd1) : RSdata_i;
        b_mag     = (!op_i[0] && RTdata_i[31]) ? (~RTdata_i + 32'd1) : RTdata_i;
        // Shift-add: add the multiplicand into the top half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        mul_sum   = {1'b0, acc_q[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);
        // Restoring step: bring in the next dividend bit, trial-subtract divisor.
        div_shift = {rem_q[31:0], a_q[31]};
        div_sub   = {1'b0, div_shift} - {2'b00, b_q};
        prod_fix  = neg_q  ? (~acc_q + 64'd1)        : acc_q;
        quo_fix   = neg_q  ? (~acc_q[31:0] + 32'd1)  : acc_q[31:0];
        rem_fix   = rneg_q ? (~rem_q[31:0] + 32'd1)  : rem_q[31:0];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rs_d    = rs_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        div0_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    // A start in the same cycle as an HI/LO write wins; the write is dropped.
                    state_d = CALC;
                    op_d    = op_i;
                    a_d     = a_mag;
                    b_d     = b_mag;
                    rs_d    = RSdata_i;
                    acc_d   = 64'd0;
                    rem_d   = 33'd0;
                    cnt_d   = 5'd0;
                    neg_d   = !op_i[0] && (RSdata_i[31] ^ RTdata_i[31]);
                    rneg_d  = (op_i == 2'b10) && RSdata_i[31];
                end else begin
                    if (hilo_we_i[1]) hi_d = RSdata_i;
                    if (hilo_we_i[0]) lo_d = RSdata_i;
                end
            end
            CALC: begin
                cnt_d = cnt_q + 5'd1;
                if (op_q[1]) begin
                    a_d = {a_q[30:0], 1'b0};
                    rem_d = div_sub[33] ? div_shift : div_sub[32:0];
                    acc_d = {32'd0, acc_q[30:0], ~div_sub[33]};
                end else begin
                    acc_d = {mul_sum, acc_q[31:1]};
                    b_d   = {1'b0, b_q[31:1]};
                end
                if (cnt_q == 5'd31) state_d = FIXUP;
            end
            FIXUP: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    if (b_q == 32'd0) begin
                        hi_d   = rs_q;
                        lo_d   = 32'hFFFF_FFFF;
                        div0_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            rs_q    <= 32'd0;
            acc_q   <= 64'd0;
            rem_q   <= 33'd0;
            cnt_q   <= 5'd0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rs_q    <= rs_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign div0_o = div0_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, scoreboard queue of
// expected {HI, LO, div0}, monitor pops on every done_o pulse.
module tb_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] RSdata_i = 32'd0;
    logic [31:0] RTdata_i = 32'd0;
    logic [1:0]  hilo_we_i = 2'b00;
    logic        busy_o, done_o, div0_o;
    logic [31:0] hi_o, lo_o;

    muldiv_unit dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .op_i      (op_i),
        .RSdata_i  (RSdata_i),
        .RTdata_i  (RTdata_i),
        .hilo_we_i (hilo_we_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .div0_o    (div0_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("hi", {32'd0, hi_o}, {32'd0, e.hi});
                check("lo", {32'd0, lo_o}, {32'd0, e.lo});
                check("div0", {63'd0, div0_o}, {63'd0, e.div0});
            end
        end else if (div0_o === 1'b1) begin
            check("div0_without_done", 64'd1, 64'd0);
        end
    end

    // Issue one op; optionally assert hilo_we together with start, and
    // optionally poke start/hilo_we again mid-operation (cycle 10).
    task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [1:0] we, input bit poke,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic ediv0);
        int   cycles;
        exp_t e;
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; RSdata_i = rs; RTdata_i = rt; hilo_we_i = we;
        e.hi = ehi; e.lo = elo; e.div0 = ediv0;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        start_i = 1'b0; hilo_we_i = 2'b00;
        RSdata_i = 32'h5555_AAAA; RTdata_i = 32'h0F0F_0F0F;
        @(negedge clk_i);
        cycles = 0;
        while (busy_o && cycles < 100) begin
            cycles++;
            if (poke && cycles == 10) begin
                start_i = 1'b1; op_i = 2'b11; RSdata_i = 32'hDEAD_BEEF;
                RTdata_i = 32'd3; hilo_we_i = 2'b11;
            end else begin
                start_i = 1'b0; hilo_we_i = 2'b00;
            end
            @(negedge clk_i);
        end
        start_i = 1'b0; hilo_we_i = 2'b00;
        check("busy_cycles", 64'(cycles), 64'd33);
        check("done_after_busy", {63'd0, done_o}, 64'd1);
        @(negedge clk_i);
        check("done_one_cycle", {63'd0, done_o}, 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        rst_i = 1'b1;

        // MULT -3 * 5
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        // MULTU / MULT on all ones
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b0, 32'h0000_0000, 32'h0000_0001, 1'b0);
        // DIV / DIVU -7, 2
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 2'b00, 1'b0, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
        // Overflow case
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 1'b0, 32'h0000_0000, 32'h8000_0000, 1'b0);
        // Divide by zero, unsigned and signed
        run_op(2'b11, 32'h0000_1234, 32'd0, 2'b00, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 2'b00, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        // Plain DIV with negative divisor: 100 / -7 -> q=-14, r=2
        run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 2'b00, 1'b0, 32'h0000_0002, 32'hFFFF_FFF2, 1'b0);

        // MULTU 6*7 with start/hilo_we poked while busy
        run_op(2'b01, 32'd6, 32'd7, 2'b00, 1'b1, 32'd0, 32'd42, 1'b0);

        // MTHI then MTLO
        @(negedge clk_i);
        hilo_we_i = 2'b10; RSdata_i = 32'hCAFE_0000;
        @(negedge clk_i);
        hilo_we_i = 2'b00;
        check("mthi", {hi_o, lo_o}, {32'hCAFE_0000, 32'd42});
        hilo_we_i = 2'b01; RSdata_i = 32'h0000_BEEF;
        @(negedge clk_i);
        hilo_we_i = 2'b00;
        check("mtlo", {hi_o, lo_o}, {32'hCAFE_0000, 32'h0000_BEEF});
        hilo_we_i = 2'b11; RSdata_i = 32'h1111_2222;
        @(negedge clk_i);
        hilo_we_i = 2'b00;
        check("mthilo", {hi_o, lo_o}, {32'h1111_2222, 32'h1111_2222});

        // start together with hilo_we: only the op happens (7 * -2 = -14)
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 2'b11, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0);

        // Reset in the middle of a DIV
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'b10; RSdata_i = 32'd100; RTdata_i = 32'd7;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check("busy_before_abort", {63'd0, busy_o}, 64'd1);
        #1;
        rst_i = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        check("abort_flags", {62'd0, done_o, div0_o}, 64'd0);
        check("abort_hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        check("abort_idle_hilo", {hi_o, lo_o}, 64'd0);

        // Normal operation after reset
        run_op(2'b01, 32'd2, 32'd3, 2'b00, 1'b0, 32'd0, 32'd6, 1'b0);

        repeat (3) @(negedge clk_i);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
